// File: rtl/cex_enum_driver_pkg.sv
// Shared types for the counterexample enumeration driver and its tag pipeline.
package cex_pkg;

  // Default configuration. Instances override the widths through their own parameters.
  localparam int N_IN_DFLT   = 61;
  localparam int N_UNIV_DFLT = 20;

  // Width of the checked-result counter.
  // It is one bit wider than the universal counter, so a full pass of
  // 2^N_UNIV results can be stored.
  localparam int CHK_W = N_UNIV_DFLT + 1;

  // Driver control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One in-flight evaluator request: the valid flag plus the vector it carries.
  typedef struct packed {
    logic                 valid;
    logic [N_IN_DFLT-1:0] vec;
  } tag_t;

endpackage

// File: rtl/cex_enum_driver_tag_pipe.sv
// Valid+data delay line that tracks vectors through the evaluator latency.
// DEPTH = 0 passes the input straight through.
module cex_tag_pipe #(
  parameter int W     = 61,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         busy
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign busy      = 1'b0;
    end else begin : g_delay
      logic [DEPTH-1:0] v;
      logic [W-1:0]     d [DEPTH];

      // Shift the tags one stage per cycle. Reset flushes every stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v <= '0;
          for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
          v[0] <= in_valid;
          d[0] <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            v[i] <= v[i-1];
            d[i] <= d[i-1];
          end
        end
      end

      assign out_valid = v[DEPTH-1];
      assign out_data  = d[DEPTH-1];
      assign busy      = |v;
    end
  endgenerate

endmodule

// File: rtl/cex_enum_driver.sv
// Drives every universal assignment for one existential candidate into the
// formula evaluator. It then reports either a pass verdict or the first
// failing vector.
//
// Handshake: a candidate transfers on a rising edge where cand_valid and
// cand_ready are both high. cand_ready is high only in IDLE, and cand_valid
// is ignored in every other state. vec_valid marks a live vec_o for exactly
// that cycle; the evaluator has no backpressure.
module cex_enum_driver
  import cex_pkg::*;
#(
  parameter int N_IN     = 61,
  parameter int N_UNIV   = 20,
  parameter int EVAL_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cand_valid,
  input  logic [N_IN-N_UNIV-1:0] cand_data,
  output logic                   cand_ready,
  output logic [N_IN-1:0]        vec_o,
  output logic                   vec_valid,
  input  logic                   result_i,
  output logic                   done,
  output logic                   pass,
  output logic                   cex_valid,
  output logic [N_IN-1:0]        cex_vec,
  output logic [N_UNIV:0]        checked_cnt
);

  state_t                 state, state_nx;
  logic [N_IN-N_UNIV-1:0] cand;
  logic [N_UNIV-1:0]      univ_cnt;
  logic                   tap_valid;
  logic [N_IN-1:0]        tap_vec;
  logic                   pipe_busy;
  logic                   accept;
  logic                   sample;
  logic                   fail_now;
  logic                   last_vec;

  assign cand_ready = (state == IDLE);
  assign vec_valid  = (state == RUN);
  assign done       = (state == DONE);
  assign vec_o      = {cand, univ_cnt};
  assign accept     = cand_valid & cand_ready;
  assign last_vec   = &univ_cnt;

  // Once the first failure is captured, later results are neither counted nor checked.
  assign sample   = tap_valid & ~cex_valid;
  assign fail_now = sample & ~result_i;

  cex_tag_pipe #(
    .W     (N_IN),
    .DEPTH (EVAL_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (vec_valid),
    .in_data   (vec_o),
    .out_valid (tap_valid),
    .out_data  (tap_vec),
    .busy      (pipe_busy)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  // A failure seen in RUN makes the current vector the last one issued.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (fail_now || last_vec) state_nx = DRAIN;
      DRAIN:   if (!pipe_busy) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: candidate latch, universal counter, result bookkeeping and verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand        <= '0;
      univ_cnt    <= '0;
      checked_cnt <= '0;
      pass        <= 1'b0;
      cex_valid   <= 1'b0;
      cex_vec     <= '0;
    end else if (accept) begin
      cand        <= cand_data;
      univ_cnt    <= '0;
      checked_cnt <= '0;
      pass        <= 1'b0;
      cex_valid   <= 1'b0;
      cex_vec     <= '0;
    end else begin
      // The counter holds on its final value, so it never wraps.
      if (state == RUN && !last_vec && !fail_now) univ_cnt <= univ_cnt + 1'b1;
      if (sample) checked_cnt <= checked_cnt + 1'b1;
      if (fail_now) begin
        cex_valid <= 1'b1;
        cex_vec   <= tap_vec;
      end
      // The pipeline is empty here, so the verdict is final and visible alongside done.
      if (state == DRAIN && !pipe_busy) pass <= ~cex_valid;
    end
  end

endmodule

// File: tb/tb_cex_enum_driver.sv
// Directed bench for cex_enum_driver.
// Three instances share a clock: EVAL_LAT = 1, 3 and 0, each with N_IN=6 and N_UNIV=4.
module tb_cex_enum_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cand_valid_a  [3];
  logic [1:0] cand_data_a   [3];
  logic       cand_ready_a  [3];
  logic [5:0] vec_o_a       [3];
  logic       vec_valid_a   [3];
  logic       result_a      [3];
  logic       done_a        [3];
  logic       pass_a        [3];
  logic       cex_valid_a   [3];
  logic [5:0] cex_vec_a     [3];
  logic [4:0] checked_cnt_a [3];

  logic [63:0] fail_set [3];
  logic [5:0]  dly      [3][4];
  logic [5:0]  exp_q[$];
  int          done_cnt [3];
  int          n_cmp = 0;
  int          n_err = 0;
  int          steps;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 0;
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cex_enum_driver #(
      .N_IN     (6),
      .N_UNIV   (4),
      .EVAL_LAT ((g == 0) ? 1 : (g == 1) ? 3 : 0)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cand_valid  (cand_valid_a[g]),
      .cand_data   (cand_data_a[g]),
      .cand_ready  (cand_ready_a[g]),
      .vec_o       (vec_o_a[g]),
      .vec_valid   (vec_valid_a[g]),
      .result_i    (result_a[g]),
      .done        (done_a[g]),
      .pass        (pass_a[g]),
      .cex_valid   (cex_valid_a[g]),
      .cex_vec     (cex_vec_a[g]),
      .checked_cnt (checked_cnt_a[g])
    );
  end

  // Evaluator model: a fixed-latency delay of vec_o, then a lookup in the fail set.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      dly[g][0] <= vec_o_a[g];
      for (int k = 1; k < 4; k++) dly[g][k] <= dly[g][k-1];
    end
  end

  always_comb begin
    for (int g = 0; g < 3; g++) begin
      result_a[g] = (lat_of(g) == 0) ? ~fail_set[g][vec_o_a[g]]
                                     : ~fail_set[g][dly[g][lat_of(g)-1]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then check every live vector against the scoreboard.
  task automatic step();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      if (done_a[g]) done_cnt[g]++;
      if (vec_valid_a[g]) begin
        chk("cand_ready_in_run", {31'b0, cand_ready_a[g]}, 32'd0);
        if (exp_q.size() == 0) chk("vec_extra", {26'b0, vec_o_a[g]}, 32'hBAD);
        else                   chk("vec_o", {26'b0, vec_o_a[g]}, {26'b0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic push_range(input logic [5:0] lo, input logic [5:0] hi);
    for (int v = int'(lo); v <= int'(hi); v++) exp_q.push_back(6'(v));
  endtask

  // Step until done is seen, with a bounded wait.
  // Unless hold is set, cand_valid is dropped after the accepting edge.
  task automatic wait_done(input int g, input bit hold, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (!hold) cand_valid_a[g] = 1'b0;
      if (done_a[g]) break;
    end
    chk("done_seen", {31'b0, done_a[g]}, 32'd1);
  endtask

  task automatic verdict(input int g, input bit p, input bit cv, input logic [5:0] cx,
                         input logic [4:0] cnt);
    chk("pass", {31'b0, pass_a[g]}, {31'b0, p});
    chk("cex_valid", {31'b0, cex_valid_a[g]}, {31'b0, cv});
    if (cv) chk("cex_vec", {26'b0, cex_vec_a[g]}, {26'b0, cx});
    chk("checked_cnt", {27'b0, checked_cnt_a[g]}, {27'b0, cnt});
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  // One cycle after done: back in IDLE, the pulse has ended and the verdict still holds.
  task automatic after_done(input int g, input bit p);
    step();
    chk("done_one_cycle", {31'b0, done_a[g]}, 32'd0);
    chk("ready_after_done", {31'b0, cand_ready_a[g]}, 32'd1);
    chk("pass_held", {31'b0, pass_a[g]}, {31'b0, p});
  endtask

  task automatic chk_cleared(input int g);
    chk("rst_cand_ready", {31'b0, cand_ready_a[g]}, 32'd1);
    chk("rst_vec_valid", {31'b0, vec_valid_a[g]}, 32'd0);
    chk("rst_done", {31'b0, done_a[g]}, 32'd0);
    chk("rst_pass", {31'b0, pass_a[g]}, 32'd0);
    chk("rst_cex_valid", {31'b0, cex_valid_a[g]}, 32'd0);
    chk("rst_vec_o", {26'b0, vec_o_a[g]}, 32'd0);
    chk("rst_cex_vec", {26'b0, cex_vec_a[g]}, 32'd0);
    chk("rst_checked", {27'b0, checked_cnt_a[g]}, 32'd0);
  endtask

  initial begin
    // Clock and reset.
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      cand_valid_a[g] = 1'b0;
      cand_data_a[g]  = 2'b00;
      fail_set[g]     = '0;
      done_cnt[g]     = 0;
    end
    step();
    step();
    for (int g = 0; g < 3; g++) chk_cleared(g);
    rst_n = 1'b1;
    step();

    // 1) Latency 1, the evaluator is always true: expect 16 vectors and a pass.
    push_range(6'h20, 6'h2F);
    cand_valid_a[0] = 1'b1; cand_data_a[0] = 2'b10;
    wait_done(0, 1'b0, steps);
    verdict(0, 1'b1, 1'b0, 6'h00, 5'd16);
    after_done(0, 1'b1);
    chk("t1_done_pulses", done_cnt[0], 32'd1);

    // 2) Latency 1, fail on 0x27. It is seen while 0x28 is issued, and that is the last vector.
    fail_set[0] = 64'd1 << 6'h27;
    push_range(6'h20, 6'h28);
    cand_valid_a[0] = 1'b1; cand_data_a[0] = 2'b10;
    wait_done(0, 1'b0, steps);
    verdict(0, 1'b0, 1'b1, 6'h27, 5'd8);
    after_done(0, 1'b0);

    // 3) Latency 3, fail on 0x20 and 0x21. Only the first failure counts.
    //    Vectors 0x20..0x23 are issued. Done comes at cycle 8 after the accept (step 9):
    //    RUN 0-3, DRAIN 4-7 while 0x21..0x23 flush.
    fail_set[1] = (64'd1 << 6'h20) | (64'd1 << 6'h21);
    push_range(6'h20, 6'h23);
    cand_valid_a[1] = 1'b1; cand_data_a[1] = 2'b10;
    wait_done(1, 1'b0, steps);
    verdict(1, 1'b0, 1'b1, 6'h20, 5'd1);
    chk("t3_done_latency", steps, 32'd9);
    after_done(1, 1'b0);

    // 4) Latency 0, fail on the last vector 0x2F.
    fail_set[2] = 64'd1 << 6'h2F;
    push_range(6'h20, 6'h2F);
    cand_valid_a[2] = 1'b1; cand_data_a[2] = 2'b10;
    wait_done(2, 1'b0, steps);
    verdict(2, 1'b0, 1'b1, 6'h2F, 5'd16);
    after_done(2, 1'b0);

    // 5) Reset pulse in the 5th RUN cycle. Outputs clear asynchronously and no done is produced.
    fail_set[0] = '0;
    done_cnt[0] = 0;
    push_range(6'h20, 6'h24);
    cand_valid_a[0] = 1'b1; cand_data_a[0] = 2'b10;
    step();
    cand_valid_a[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    chk_cleared(0);
    chk("t5_queue_used", exp_q.size(), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t5_no_done", done_cnt[0], 32'd0);
    push_range(6'h10, 6'h1F);
    cand_valid_a[0] = 1'b1; cand_data_a[0] = 2'b01;
    wait_done(0, 1'b0, steps);
    verdict(0, 1'b1, 1'b0, 6'h00, 5'd16);
    after_done(0, 1'b1);

    // 6) cand_valid is held high with new data during RUN. It is ignored until done,
    //    and the new candidate is then accepted in the following IDLE cycle.
    push_range(6'h20, 6'h2F);
    cand_valid_a[0] = 1'b1; cand_data_a[0] = 2'b10;
    step();
    cand_data_a[0] = 2'b11;
    wait_done(0, 1'b1, steps);
    verdict(0, 1'b1, 1'b0, 6'h00, 5'd16);
    push_range(6'h30, 6'h3F);
    step();
    chk("t6_idle_ready", {31'b0, cand_ready_a[0]}, 32'd1);
    wait_done(0, 1'b0, steps);
    verdict(0, 1'b1, 1'b0, 6'h00, 5'd16);
    after_done(0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
